// File: rtl/scope_capture_writer.sv
// Scope capture front end: packs 16-bit ADC samples in pairs and writes them into a circular
// sample memory. Handles pre-trigger fill, edge/forced trigger, post-trigger fill and the done report.
//
// state   | meaning
// S_IDLE  | waiting for arm, no writes
// S_PREFILL | filling the pre-trigger words, edges ignored
// S_ARMED | writing circularly, watching for a trigger edge
// S_POST  | trigger seen, counting down the remaining post-trigger words
// S_DONE  | frame complete, done held until the next arm or abort
module scope_capture_writer #(
  parameter int DEPTH  = 25000,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       sample,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [15:0]       trig_level,
  input  logic              trig_falling,
  input  logic [ADDR_W-1:0] pre_words,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int                CNT_W     = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t            state;
  logic              phase;
  logic [15:0]       lo_half;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [CNT_W-1:0]  post_cnt;
  logic [CNT_W-1:0]  post_len;
  logic [15:0]       level_q;
  logic              falling_q;
  logic [15:0]       prev;
  logic              prev_ok;
  logic              force_pend;

  logic [ADDR_W-1:0] pre_eff;
  logic [ADDR_W-1:0] ptr_next;
  logic              take;
  logic              complete;
  logic              level_edge;
  logic              edge_hit;

  always_comb begin
    pre_eff    = (32'(pre_words) >= 32'(DEPTH)) ? LAST_ADDR : pre_words;
    ptr_next   = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
    take       = sample_valid && (state == S_PREFILL || state == S_ARMED || state == S_POST);
    complete   = take && phase;
    level_edge = falling_q ? (prev > level_q && sample <= level_q)
                           : (prev < level_q && sample >= level_q);
    // a forced trigger is honoured on the first valid sample seen while armed
    edge_hit   = take && (state == S_ARMED) &&
                 ((prev_ok && level_edge) || force_trig || force_pend);
  end

  assign mem_chipselect = mem_write;
  assign mem_byteenable = 4'b1111;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      phase         <= 1'b0;
      lo_half       <= '0;
      wr_ptr        <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
      post_len      <= '0;
      level_q       <= '0;
      falling_q     <= 1'b0;
      prev          <= '0;
      prev_ok       <= 1'b0;
      force_pend    <= 1'b0;
      mem_address   <= '0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      trig_addr     <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      phase      <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      prev_ok    <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      mem_write <= 1'b0;

      if (take) begin
        prev    <= sample;
        prev_ok <= 1'b1;
        phase   <= ~phase;
        if (!phase) begin
          lo_half <= sample;
        end else begin
          mem_write     <= 1'b1;
          mem_address   <= wr_ptr;
          mem_writedata <= {sample, lo_half};
          wr_ptr        <= ptr_next;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            level_q    <= trig_level;
            falling_q  <= trig_falling;
            pre_cnt    <= pre_eff;
            post_len   <= DEPTH_CNT - CNT_W'(pre_eff);
            post_cnt   <= '0;
            wr_ptr     <= '0;
            phase      <= 1'b0;
            prev_ok    <= 1'b0;
            force_pend <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= (pre_eff == '0) ? S_ARMED : S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (complete) begin
            pre_cnt <= pre_cnt - ADDR_W'(1);
            if (pre_cnt == ADDR_W'(1)) state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (force_trig && !take) force_pend <= 1'b1;
          if (edge_hit) begin
            force_pend <= 1'b0;
            trig_addr  <= wr_ptr;
            // trigger on the completing sample: this write is already the first post word
            if (complete) begin
              post_cnt <= post_len - CNT_W'(1);
              if (post_len == CNT_W'(1)) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_POST;
              end
            end else begin
              post_cnt <= post_len;
              state    <= S_POST;
            end
          end
        end
        S_POST: begin
          if (complete) begin
            post_cnt <= post_cnt - CNT_W'(1);
            if (post_cnt == CNT_W'(1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scope_capture_writer.sv
// Scoreboard bench for scope_capture_writer: a sample-index level model predicts every memory
// write, the trigger word and the done flag; a negedge monitor pops and compares the writes.
module tb_scope_capture_writer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [15:0]       sample = '0;
  logic              sample_valid = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              force_trig = 1'b0;
  logic [15:0]       trig_level = '0;
  logic              trig_falling = 1'b0;
  logic [ADDR_W-1:0] pre_words = '0;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;

  always #5 clk = ~clk;

  scope_capture_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .arm            (arm),
    .abort          (abort),
    .force_trig     (force_trig),
    .trig_level     (trig_level),
    .trig_falling   (trig_falling),
    .pre_words      (pre_words),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .busy           (busy),
    .done           (done),
    .trig_addr      (trig_addr)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  smp[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (reset_n && mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%0d actual_data=%h required=none",
                 mem_address, mem_writedata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(e.addr));
        chk("wr_data", mem_writedata, e.data);
        chk("wr_cs_be", {27'd0, mem_chipselect, mem_byteenable}, {27'd0, 1'b1, 4'hF});
      end
    end
  end

  function automatic int clamp_pre(int p);
    return (p >= DEPTH) ? DEPTH - 1 : p;
  endfunction

  // First sample index that triggers: only samples after the pre-trigger words are eligible,
  // and sample 0 has no predecessor.
  function automatic int find_trig(int pre, int level, bit falling, int force_idx);
    for (int i = 2 * pre; i < smp.size(); i++) begin
      if (i == force_idx) return i;
      if (i > 0) begin
        if (!falling && smp[i-1] < level && smp[i] >= level) return i;
        if (falling && smp[i-1] > level && smp[i] <= level) return i;
      end
    end
    return -1;
  endfunction

  task automatic load_model(input int pre_raw, input int level, input bit falling,
                            input int force_idx, input int n_fed,
                            output bit exp_done, output int exp_ta);
    int pre, t, last;
    pre      = clamp_pre(pre_raw);
    t        = find_trig(pre, level, falling, force_idx);
    last     = (t < 0) ? n_fed : t / 2 + (DEPTH - pre) - 1;
    exp_done = (t >= 0) && (2 * last + 1 < n_fed);
    exp_ta   = (t < 0) ? 0 : (t / 2) % DEPTH;
    for (int k = 0; k <= last && 2 * k + 1 < n_fed; k++)
      exp_q.push_back('{addr: ADDR_W'(k % DEPTH), data: {16'(smp[2*k+1]), 16'(smp[2*k])}});
  endtask

  task automatic arm_cfg(input int pre_raw, input int level, input bit falling);
    sample_valid = 1'b0;
    arm          = 1'b1;
    trig_level   = 16'(level);
    trig_falling = falling;
    pre_words    = ADDR_W'(pre_raw);
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic feed(input int n_fed, input int force_idx, input bit gaps);
    for (int i = 0; i < n_fed; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        sample_valid = 1'b0;
        force_trig   = 1'b0;
        sample       = 16'($urandom);
        @(posedge clk); #1;
      end
      sample_valid = 1'b1;
      sample       = 16'(smp[i]);
      force_trig   = (i == force_idx);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    force_trig   = 1'b0;
  endtask

  task automatic run_capture(input string tag, input int pre_raw, input int level,
                             input bit falling, input int force_idx, input int n_fed,
                             input bit gaps);
    bit ed;
    int eta;
    load_model(pre_raw, level, falling, force_idx, n_fed, ed, eta);
    arm_cfg(pre_raw, level, falling);
    feed(n_fed, force_idx, gaps);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(done), 32'(ed));
    chk({tag, "_busy"}, 32'(busy), 32'(!ed));
    if (ed) chk({tag, "_trig_addr"}, 32'(trig_addr), 32'(eta));
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit ed;
    int eta;

    #22 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_trig_addr", 32'(trig_addr), 32'd0);

    // ramp 0,10,20..: trigger on sample 100 (word 5)
    smp.delete();
    for (int i = 0; i < 40; i++) smp.push_back(i * 10);
    run_capture("ramp", 4, 100, 1'b0, -1, 40, 1'b0);

    // trigger after 40 words: pointer wraps, trigger word 8, last write at 3
    smp.delete();
    for (int i = 0; i < 80; i++) smp.push_back(50);
    for (int i = 0; i < 30; i++) smp.push_back(200);
    run_capture("wrap", 4, 100, 1'b0, -1, 110, 1'b0);

    // falling edge on 0x9000 -> 0x8000
    smp.delete();
    smp.push_back(16'h9000);
    for (int i = 0; i < 40; i++) smp.push_back(16'h8000);
    run_capture("fall_hit", 0, 16'h8000, 1'b1, -1, 36, 1'b0);

    // 0x8000 -> 0x8000 must not trigger; first real edge at sample 7
    smp.delete();
    for (int i = 0; i < 6; i++) smp.push_back(16'h8000);
    smp.push_back(16'h9000);
    for (int i = 0; i < 40; i++) smp.push_back(16'h7000);
    run_capture("fall_flat", 0, 16'h8000, 1'b1, -1, 42, 1'b0);

    // pre_words beyond depth clamps to 15; forced trigger gives one post word
    smp.delete();
    for (int i = 0; i < 40; i++) smp.push_back(0);
    run_capture("clamp_force_lo", 20, 1000, 1'b0, 30, 36, 1'b0);
    run_capture("clamp_force_hi", 20, 1000, 1'b0, 31, 36, 1'b0);

    // abort together with arm while in POST
    smp.delete();
    for (int i = 0; i < 40; i++) smp.push_back(i * 10);
    load_model(4, 100, 1'b0, -1, 14, ed, eta);
    arm_cfg(4, 100, 1'b0);
    feed(14, -1, 1'b0);
    abort = 1'b1;
    arm   = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    arm   = 1'b0;
    chk("abort_outputs", {29'd0, mem_write, busy, done}, 32'd0);
    chk("abort_writes_left", 32'(exp_q.size()), 32'd0);
    feed(10, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_stays_idle", {30'd0, busy, done}, 32'd0);

    // asynchronous reset while a POST write is on the bus
    load_model(4, 100, 1'b0, -1, 14, ed, eta);
    arm_cfg(4, 100, 1'b0);
    feed(14, -1, 1'b0);
    chk("pre_reset_write", 32'(mem_write), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("reset_async_write", {30'd0, mem_write, mem_chipselect}, 32'd0);
    chk("reset_inflight_dropped", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ctrl", {27'd0, mem_write, mem_chipselect, busy, done, 1'b0}, 32'd0);
    chk("post_reset_addr", 32'(mem_address), 32'd0);
    chk("post_reset_data", mem_writedata, 32'd0);
    chk("post_reset_trig", 32'(trig_addr), 32'd0);

    for (int r = 0; r < 10; r++) begin
      int pre_raw, lvl, t, f, last, n, v;
      bit fall;
      pre_raw = $urandom_range(0, 20);
      lvl     = $urandom_range(100, 900);
      fall    = 1'($urandom_range(0, 1));
      smp.delete();
      v = $urandom_range(0, 1023);
      for (int i = 0; i < 200; i++) begin
        v += int'($urandom_range(0, 128)) - 64;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        smp.push_back(v);
      end
      f = -1;
      t = find_trig(clamp_pre(pre_raw), lvl, fall, -1);
      if (t < 0 || t > 100) begin
        f = 2 * clamp_pre(pre_raw) + $urandom_range(0, 20);
        t = find_trig(clamp_pre(pre_raw), lvl, fall, f);
      end
      last = t / 2 + DEPTH - clamp_pre(pre_raw) - 1;
      n    = 2 * last + 2 + $urandom_range(0, 6);
      run_capture("rand", pre_raw, lvl, fall, f, n, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
